hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard controller for the 5-stage MIPS pipeline. It generates the PC/IF-ID write enables and the ID/EX control-bubble select. Compared with the single-cycle load-use detector it replaces, it adds:
- a multi-cycle load-use stall counter for slow data memory;
- a taken-branch flush sequence of configurable length;
- optional EX-stage forwarding selects.

It sits in the ID stage and observes the ID, EX, MEM and WB register specifiers.

## Interface
Parameters:
- REG_W, 5, register-specifier width
- LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard (1..15)
- FLUSH_CYCLES, 1, cycles IF/ID is flushed after a taken branch (1..7)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt  in  REG_W  source specifiers of the instruction in IF/ID
- ex_rs, ex_rt  in  REG_W  source specifiers of the instruction in ID/EX
- ex_rd  in  REG_W  destination of the ID/EX instruction (already muxed rt/rd)
- ex_memread  in  1  ID/EX instruction is a load (destination is ex_rt)
- ex_regwrite  in  1  ID/EX instruction writes a register
- mem_rd, wb_rd  in  REG_W  destinations in EX/MEM and MEM/WB
- mem_regwrite, wb_regwrite  in  1  write enables in EX/MEM and MEM/WB
- branch_taken  in  1  branch resolved taken in EX this cycle
- PCwrite  out  1  1 = PC updates
- IFIDwrite  out  1  1 = IF/ID register loads
- Ctrl_IDEX_mux  out  1  1 = pass decoded controls into ID/EX, 0 = insert bubble
- IFIDflush  out  1  1 = IF/ID is cleared to a NOP
- fwdA, fwdB  out  2  EX operand select: 00 regfile, 10 from EX/MEM, 01 from MEM/WB

## Operation
- State machine RUN / STALL / FLUSH. Two counters:
  - stall_cnt, 4 bits;
  - flush_cnt, 3 bits.
- Specifier value 0 never produces a hazard or a forward.
- Load-use hazard (lu): ex_memread && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt).
- RUN:
  - If branch_taken: assert IFIDflush=1 and Ctrl_IDEX_mux=0. If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1.
  - Else if lu: assert PCwrite=0, IFIDwrite=0, Ctrl_IDEX_mux=0. If LOAD_STALL_CYCLES>1, go to STALL with stall_cnt=LOAD_STALL_CYCLES-1.
  - Otherwise all enables are 1 and flush is 0.
- STALL:
  - PCwrite, IFIDwrite and Ctrl_IDEX_mux are 0.
  - stall_cnt decrements each cycle; return to RUN after the cycle in which stall_cnt==1.
  - branch_taken in STALL has priority: flush behaviour applies, stall_cnt is cleared, next state is FLUSH or RUN as in the RUN rule.
- FLUSH:
  - IFIDflush=1, Ctrl_IDEX_mux=0, PCwrite=1, IFIDwrite=1.
  - flush_cnt decrements; return to RUN after the cycle in which flush_cnt==1.
  - lu is ignored while in FLUSH.
- Forwarding, per operand; fwdA uses ex_rs, fwdB uses ex_rt:
  - 10 if mem_regwrite && mem_rd!=0 && mem_rd==src;
  - else 01 if wb_regwrite && wb_rd!=0 && wb_rd==src;
  - else 00.
  - EX/MEM wins when both match.

## Timing
- Hazard outputs are combinational from the current state plus current inputs. Detection acts in the same cycle as the hazard appears, with no one-cycle lag.
- State and counters are registered on the rising edge of clk.
- A load-use hazard gives exactly LOAD_STALL_CYCLES bubble cycles.
- A taken branch gives exactly FLUSH_CYCLES flush cycles.
- Reset (rst_n=0) is asynchronous and may occur mid-stall or mid-flush:
  - state becomes RUN immediately and both counters become 0;
  - while rst_n=0, PCwrite=0, IFIDwrite=0, Ctrl_IDEX_mux=0, IFIDflush=0, fwdA=fwdB=00.
- After rst_n deasserts, the first rising edge operates in RUN.

## Configuration
- HAZARD_FWD_EN defined: forwarding logic as above; stalls only on load-use.
- HAZARD_FWD_EN undefined:
  - fwdA=fwdB=00 always.
  - An additional RAW stall (PCwrite=IFIDwrite=Ctrl_IDEX_mux=0) is asserted combinationally whenever the rule below holds, for either of id_rs / id_rt (nonzero):
    - (ex_regwrite && ex_rd matches), or
    - (mem_regwrite && mem_rd matches).
  - The RAW stall uses no counter; it is re-evaluated every cycle in RUN.
  - The register file is write-first, so WB needs no stall.

## Test plan
- Reset: rst_n=0 in the middle of a 3-cycle stall -> all outputs 0 immediately; after release, no hazard gives PCwrite=IFIDwrite=Ctrl_IDEX_mux=1.
- Load-use, LOAD_STALL_CYCLES=3: ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> PCwrite=0 for exactly 3 cycles, then 1.
- Zero register: ex_memread=1, ex_rt=0, id_rt=0 -> no stall. Likewise mem_rd=0 with mem_regwrite=1 and ex_rs=0 -> fwdA=00.
- Branch priority, FLUSH_CYCLES=2: branch_taken and lu in the same cycle -> IFIDflush=1 for 2 cycles, PCwrite stays 1, no stall.
- Forward priority (HAZARD_FWD_EN): mem_rd=wb_rd=ex_rs=5, both regwrite=1 -> fwdA=10. With mem_regwrite=0 -> fwdA=01.
- No forwarding (macro off): ex_regwrite=1, ex_rd=9, id_rt=9 -> stall asserted. Next cycle with ex_rd=0 and mem_rd=9, mem_regwrite=1 -> still stalled. Then released.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS pipeline: multi-cycle load-use stall, taken-branch flush, EX forwarding.
// Define HAZARD_FWD_EN to enable EX forwarding; without it, RAW hazards against EX/MEM stall instead.
module hazard_ctrl #(
   parameter int REG_W             = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic [REG_W-1:0] mem_rd,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             mem_regwrite,
   input  logic             wb_regwrite,
   input  logic             branch_taken,
   output logic             PCwrite,
   output logic             IFIDwrite,
   output logic             Ctrl_IDEX_mux,
   output logic             IFIDflush,
   output logic [1:0]       fwdA,
   output logic [1:0]       fwdB,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL_CYCLES - 1);
   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   state_t     r_state;
   logic [3:0] r_stall_cnt;
   logic [2:0] r_flush_cnt;

   state_t     w_next_state;
   logic [3:0] w_next_stall;
   logic [2:0] w_next_flush;
   logic       w_pcwrite;
   logic       w_ifidwrite;
   logic       w_ctrl;
   logic       w_flush;
   logic       w_lu;
   logic       w_raw;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   assign w_lu = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

`ifdef HAZARD_FWD_EN
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
      if (mem_regwrite && (mem_rd != '0) && (mem_rd == src))
         return 2'b10;
      else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   logic w_unused_fwd;
   assign w_unused_fwd = ^{ex_regwrite, ex_rd};
   assign w_raw   = 1'b0;
   assign w_fwd_a = fwd_sel(ex_rs);
   assign w_fwd_b = fwd_sel(ex_rt);
`else
   // Register file is write-first, so only EX and MEM producers need a stall.
   function automatic logic raw_hit(input logic [REG_W-1:0] src);
      return (src != '0) &&
             ((ex_regwrite && (ex_rd == src)) || (mem_regwrite && (mem_rd == src)));
   endfunction

   logic w_unused_nofwd;
   assign w_unused_nofwd = ^{ex_rs, wb_rd, wb_regwrite};
   assign w_raw   = raw_hit(id_rs) || raw_hit(id_rt);
   assign w_fwd_a = 2'b00;
   assign w_fwd_b = 2'b00;
`endif

   always_comb begin
      w_pcwrite    = 1'b1;
      w_ifidwrite  = 1'b1;
      w_ctrl       = 1'b1;
      w_flush      = 1'b0;
      w_next_state = r_state;
      w_next_stall = r_stall_cnt;
      w_next_flush = r_flush_cnt;
      case (r_state)
         RUN: begin
            if (branch_taken) begin
               w_flush = 1'b1;
               w_ctrl  = 1'b0;
               if (FLUSH_CYCLES > 1) begin
                  w_next_state = FLUSH;
                  w_next_flush = FLUSH_INIT;
               end
            end else if (w_lu) begin
               w_pcwrite   = 1'b0;
               w_ifidwrite = 1'b0;
               w_ctrl      = 1'b0;
               if (LOAD_STALL_CYCLES > 1) begin
                  w_next_state = STALL;
                  w_next_stall = STALL_INIT;
               end
            end else if (w_raw) begin
               w_pcwrite   = 1'b0;
               w_ifidwrite = 1'b0;
               w_ctrl      = 1'b0;
            end
         end
         STALL: begin
            // A taken branch kills the stalled instruction, so the stall is abandoned.
            if (branch_taken) begin
               w_flush      = 1'b1;
               w_ctrl       = 1'b0;
               w_next_stall = 4'd0;
               if (FLUSH_CYCLES > 1) begin
                  w_next_state = FLUSH;
                  w_next_flush = FLUSH_INIT;
               end else begin
                  w_next_state = RUN;
               end
            end else begin
               w_pcwrite    = 1'b0;
               w_ifidwrite  = 1'b0;
               w_ctrl       = 1'b0;
               w_next_stall = r_stall_cnt - 4'd1;
               if (r_stall_cnt == 4'd1)
                  w_next_state = RUN;
            end
         end
         FLUSH: begin
            w_flush      = 1'b1;
            w_ctrl       = 1'b0;
            w_next_flush = r_flush_cnt - 3'd1;
            if (r_flush_cnt == 3'd1)
               w_next_state = RUN;
         end
         default: w_next_state = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_stall_cnt <= 4'd0;
         r_flush_cnt <= 3'd0;
      end else begin
         r_state     <= w_next_state;
         r_stall_cnt <= w_next_stall;
         r_flush_cnt <= w_next_flush;
      end
   end

   // Outputs are forced low combinationally for the whole time reset is held.
   assign PCwrite       = rst_n & w_pcwrite;
   assign IFIDwrite     = rst_n & w_ifidwrite;
   assign Ctrl_IDEX_mux = rst_n & w_ctrl;
   assign IFIDflush     = rst_n & w_flush;
   assign fwdA          = rst_n ? w_fwd_a : 2'b00;
   assign fwdB          = rst_n ? w_fwd_b : 2'b00;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2) with a queue-based scoreboard.
module tb_hazard_ctrl;

   localparam int W = 10;
`ifdef HAZARD_FWD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif
   localparam logic [1:0] S_RUN = 2'd0, S_STALL = 2'd1, S_FLUSH = 2'd2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic       ex_memread, ex_regwrite, mem_regwrite, wb_regwrite, branch_taken;
   logic       PCwrite, IFIDwrite, Ctrl_IDEX_mux, IFIDflush;
   logic [1:0] fwdA, fwdB, o_dbg_state;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_checks = 0;
   int           n_err    = 0;
   bit           done     = 1'b0;

   hazard_ctrl #(.REG_W(5), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
      .branch_taken(branch_taken),
      .PCwrite(PCwrite), .IFIDwrite(IFIDwrite), .Ctrl_IDEX_mux(Ctrl_IDEX_mux),
      .IFIDflush(IFIDflush), .fwdA(fwdA), .fwdB(fwdB), .o_dbg_state(o_dbg_state)
   );

   // Clock / reset.
   always #5 clk = ~clk;

   function automatic logic [W-1:0] ev(input logic pc, input logic ifid, input logic ctrl,
                                       input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                                       input logic [1:0] st);
      return {pc, ifid, ctrl, fl, fa, fb, st};
   endfunction

   // Driver tasks.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
      ex_memread = 0; ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0; branch_taken = 0;
   endtask

   task automatic expect_out(input string nm, input logic [W-1:0] e);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic load_use();
      idle_inputs();
      ex_memread = 1; ex_rt = 8; id_rs = 8;
   endtask

   // Monitor / scoreboard: one expectation is consumed per falling edge.
   always @(negedge clk) begin
      logic [W-1:0] e, got;
      string nm;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         got = {PCwrite, IFIDwrite, Ctrl_IDEX_mux, IFIDflush, fwdA, fwdB, o_dbg_state};
         n_checks++;
         if (got !== e) begin
            n_err++;
            $display("FAIL %s: got pc/ifid/ctrl/flush/fA/fB/st=%b required=%b", nm, got, e);
         end
      end
   end

   initial begin
      #20000;
      if (!done) begin
         n_err++;
         $display("FAIL timeout: bench did not complete, %0d expectations pending", exp_q.size());
         $display("Result: errors=%0d of %0d checks", n_err, n_checks);
         $finish;
      end
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      next_cycle();
      expect_out("reset_hold", ev(0, 0, 0, 0, 2'b00, 2'b00, S_RUN));
      next_cycle();
      rst_n = 1'b1;
      expect_out("post_reset_idle", ev(1, 1, 1, 0, 2'b00, 2'b00, S_RUN));

      // Load-use: three bubble cycles, then release.
      next_cycle(); load_use();
      expect_out("lu_detect", ev(0, 0, 0, 0, 2'b00, 2'b00, S_RUN));
      next_cycle(); idle_inputs();
      expect_out("lu_stall2", ev(0, 0, 0, 0, 2'b00, 2'b00, S_STALL));
      next_cycle();
      expect_out("lu_stall3", ev(0, 0, 0, 0, 2'b00, 2'b00, S_STALL));
      next_cycle();
      expect_out("lu_release", ev(1, 1, 1, 0, 2'b00, 2'b00, S_RUN));

      // Register zero never hazards or forwards.
      next_cycle(); idle_inputs(); ex_memread = 1; ex_rt = 0; id_rt = 0;
      expect_out("lu_zero_reg", ev(1, 1, 1, 0, 2'b00, 2'b00, S_RUN));
      next_cycle(); idle_inputs(); mem_regwrite = 1; mem_rd = 0; ex_rs = 0;
      expect_out("fwd_zero_reg", ev(1, 1, 1, 0, 2'b00, 2'b00, S_RUN));

      // Branch beats load-use; lu held into FLUSH is ignored.
      next_cycle(); load_use(); branch_taken = 1;
      expect_out("br_over_lu", ev(1, 1, 0, 1, 2'b00, 2'b00, S_RUN));
      next_cycle(); branch_taken = 0;
      expect_out("flush2_lu_ignored", ev(1, 1, 0, 1, 2'b00, 2'b00, S_FLUSH));
      next_cycle(); idle_inputs();
      expect_out("flush_done", ev(1, 1, 1, 0, 2'b00, 2'b00, S_RUN));

      // Forwarding priority.
      next_cycle(); idle_inputs(); ex_rs = 5; mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1;
      expect_out("fwdA_mem_wins", ev(1, 1, 1, 0, FWD_ON ? 2'b10 : 2'b00, 2'b00, S_RUN));
      next_cycle(); mem_regwrite = 0;
      expect_out("fwdA_from_wb", ev(1, 1, 1, 0, FWD_ON ? 2'b01 : 2'b00, 2'b00, S_RUN));
      next_cycle(); idle_inputs(); ex_rt = 7; wb_rd = 7; wb_regwrite = 1; mem_rd = 3; mem_regwrite = 1;
      expect_out("fwdB_from_wb", ev(1, 1, 1, 0, 2'b00, FWD_ON ? 2'b01 : 2'b00, S_RUN));
      next_cycle(); idle_inputs(); ex_rs = 4; ex_rt = 4; mem_rd = 4; mem_regwrite = 1;
      expect_out("fwdAB_from_mem", ev(1, 1, 1, 0, FWD_ON ? 2'b10 : 2'b00, FWD_ON ? 2'b10 : 2'b00, S_RUN));

      // RAW stall without forwarding (no stall when forwarding exists).
      next_cycle(); idle_inputs(); ex_regwrite = 1; ex_rd = 9; id_rt = 9;
      expect_out("raw_ex", ev(FWD_ON, FWD_ON, FWD_ON, 0, 2'b00, 2'b00, S_RUN));
      next_cycle(); ex_rd = 0; mem_rd = 9; mem_regwrite = 1;
      expect_out("raw_mem", ev(FWD_ON, FWD_ON, FWD_ON, 0, 2'b00, 2'b00, S_RUN));
      next_cycle(); idle_inputs(); wb_rd = 9; wb_regwrite = 1; id_rt = 9;
      expect_out("raw_wb_no_stall", ev(1, 1, 1, 0, 2'b00, 2'b00, S_RUN));

      // Branch during STALL wins and enters FLUSH.
      next_cycle(); load_use();
      expect_out("lu2_detect", ev(0, 0, 0, 0, 2'b00, 2'b00, S_RUN));
      next_cycle(); idle_inputs(); branch_taken = 1;
      expect_out("br_in_stall", ev(1, 1, 0, 1, 2'b00, 2'b00, S_STALL));
      next_cycle(); branch_taken = 0;
      expect_out("br_in_stall_flush2", ev(1, 1, 0, 1, 2'b00, 2'b00, S_FLUSH));
      next_cycle();
      expect_out("br_in_stall_done", ev(1, 1, 1, 0, 2'b00, 2'b00, S_RUN));

      // Asynchronous reset in the middle of a stall.
      next_cycle(); load_use();
      expect_out("lu3_detect", ev(0, 0, 0, 0, 2'b00, 2'b00, S_RUN));
      next_cycle();
      expect_out("lu3_stall2", ev(0, 0, 0, 0, 2'b00, 2'b00, S_STALL));
      next_cycle(); rst_n = 1'b0;
      expect_out("reset_mid_stall", ev(0, 0, 0, 0, 2'b00, 2'b00, S_RUN));
      next_cycle(); idle_inputs(); rst_n = 1'b1;
      expect_out("post_reset2_idle", ev(1, 1, 1, 0, 2'b00, 2'b00, S_RUN));
      next_cycle(); load_use();
      expect_out("lu4_detect", ev(0, 0, 0, 0, 2'b00, 2'b00, S_RUN));
      next_cycle(); idle_inputs();
      expect_out("lu4_stall2", ev(0, 0, 0, 0, 2'b00, 2'b00, S_STALL));
      next_cycle();
      expect_out("lu4_stall3", ev(0, 0, 0, 0, 2'b00, 2'b00, S_STALL));
      next_cycle();
      expect_out("lu4_release", ev(1, 1, 1, 0, 2'b00, 2'b00, S_RUN));

      // Drain the scoreboard, then report.
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
